// File: rtl/bullet_pkg.sv
// Shared colour codes, default arena size and the default-width bullet slot record.
package bullet_pkg;

  typedef enum logic [2:0] {
    WHITE  = 3'd0,
    BLUE   = 3'd1,
    ORANGE = 3'd2,
    GREEN  = 3'd3
  } color_e;

  localparam int FIELD_MAX_DEFAULT = 200;
  localparam int SLOT_COORD_W      = 8;
  localparam int SLOT_VEL_W        = 4;

  typedef struct packed {
    logic                    live;
    logic [SLOT_COORD_W-1:0] x;
    logic [SLOT_COORD_W-1:0] y;
    logic [SLOT_VEL_W-1:0]   dx;
    logic [SLOT_VEL_W-1:0]   dy;
    logic [SLOT_COORD_W-1:0] size;
    logic [2:0]              color;
  } bullet_slot_t;

endpackage

// File: rtl/bullet_aabb.sv
// Combinational overlap test of two square boxes; touching edges count as overlap.
module bullet_aabb #(
  parameter int COORD_W = 8
) (
  input  logic [COORD_W-1:0] i_ax,
  input  logic [COORD_W-1:0] i_ay,
  input  logic [COORD_W-1:0] i_asize,
  input  logic [COORD_W-1:0] i_bx,
  input  logic [COORD_W-1:0] i_by,
  input  logic [COORD_W-1:0] i_bsize,
  output logic               o_overlap
);

  logic [COORD_W:0] w_ax_end;
  logic [COORD_W:0] w_ay_end;
  logic [COORD_W:0] w_bx_end;
  logic [COORD_W:0] w_by_end;

  // One extra bit so far edges near the top of the coordinate range cannot wrap.
  assign w_ax_end = {1'b0, i_ax} + {1'b0, i_asize};
  assign w_ay_end = {1'b0, i_ay} + {1'b0, i_asize};
  assign w_bx_end = {1'b0, i_bx} + {1'b0, i_bsize};
  assign w_by_end = {1'b0, i_by} + {1'b0, i_bsize};

  assign o_overlap = ({1'b0, i_ax} <= w_bx_end) && ({1'b0, i_bx} <= w_ax_end) &&
                     ({1'b0, i_ay} <= w_by_end) && ({1'b0, i_by} <= w_ay_end);

endmodule

// File: rtl/bullet_field.sv
// Multi-slot bullet engine: spawn, tick movement, player collision with iframes, render read port.
// Define BULLET_WRAP_EN to wrap out-of-arena bullets modulo FIELD_MAX+1 instead of retiring them.
module bullet_field
  import bullet_pkg::*;
#(
  parameter int N_BULLETS    = 8,
  parameter int COORD_W      = 8,
  parameter int FIELD_MAX    = FIELD_MAX_DEFAULT,
  parameter int IFRAME_TICKS = 10,
  parameter int VEL_W        = 4,
  localparam int IDX_W = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1,
  localparam int CNT_W = $clog2(N_BULLETS) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 run,
  input  logic                 spawn_valid,
  output logic                 spawn_ready,
  input  logic [COORD_W-1:0]   spawn_x,
  input  logic [COORD_W-1:0]   spawn_y,
  input  logic [VEL_W-1:0]     spawn_dx,
  input  logic [VEL_W-1:0]     spawn_dy,
  input  logic [COORD_W-1:0]   spawn_size,
  input  logic [2:0]           spawn_color,
  input  logic [COORD_W-1:0]   player_x,
  input  logic [COORD_W-1:0]   player_y,
  input  logic [COORD_W-1:0]   player_size,
  input  logic                 player_moving,
  output logic                 hit_valid,
  output logic [IDX_W-1:0]     hit_index,
  output logic [2:0]           hit_color,
  output logic                 iframe_active,
  output logic [N_BULLETS-1:0] live_mask,
  output logic [CNT_W-1:0]     live_count,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [COORD_W-1:0]   rd_x,
  output logic [COORD_W-1:0]   rd_y,
  output logic [COORD_W-1:0]   rd_size,
  output logic [2:0]           rd_color,
  output logic                 rd_live
);

  localparam int SW  = COORD_W + 2;
  localparam int IFW = (IFRAME_TICKS > 0) ? $clog2(IFRAME_TICKS + 1) : 1;

  typedef struct packed {
    logic               live;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [VEL_W-1:0]   dx;
    logic [VEL_W-1:0]   dy;
    logic [COORD_W-1:0] size;
    logic [2:0]         color;
  } slot_t;

  slot_t          r_slot [N_BULLETS];
  logic           r_hit_valid;
  logic [IDX_W-1:0] r_hit_index;
  logic [2:0]     r_hit_color;
  logic [IFW-1:0] r_iframe;

  logic [N_BULLETS-1:0] w_overlap;
  logic [N_BULLETS-1:0] w_eligible;
  logic [N_BULLETS-1:0] w_retire;
  logic [N_BULLETS-1:0] w_live;
  logic [COORD_W-1:0]   w_px [N_BULLETS];
  logic [COORD_W-1:0]   w_py [N_BULLETS];
  logic                 w_free_any;
  logic [IDX_W-1:0]     w_free_idx;
  logic                 w_hit_any;
  logic [IDX_W-1:0]     w_hit_idx;
  logic [2:0]           w_hit_color;
  logic [CNT_W-1:0]     w_count;
  logic                 w_accept;
  logic                 w_iframe_idle;
  slot_t                w_rd;

  for (genvar g = 0; g < N_BULLETS; g++) begin : g_aabb
    bullet_aabb #(.COORD_W(COORD_W)) u_aabb (
      .i_ax      (r_slot[g].x),
      .i_ay      (r_slot[g].y),
      .i_asize   (r_slot[g].size),
      .i_bx      (player_x),
      .i_by      (player_y),
      .i_bsize   (player_size),
      .o_overlap (w_overlap[g])
    );
  end

  // Next position per slot; positions are widened and signed so negative results are visible.
  always_comb begin
    logic signed [SW-1:0] nx, ny, lim;
    for (int i = 0; i < N_BULLETS; i++) begin
      nx  = $signed({2'b00, r_slot[i].x}) + SW'($signed(r_slot[i].dx));
      ny  = $signed({2'b00, r_slot[i].y}) + SW'($signed(r_slot[i].dy));
      lim = SW'(FIELD_MAX) - $signed({2'b00, r_slot[i].size});
`ifdef BULLET_WRAP_EN
      if (nx < 0) nx = nx + SW'(FIELD_MAX + 1);
      else if (nx > SW'(FIELD_MAX)) nx = nx - SW'(FIELD_MAX + 1);
      if (ny < 0) ny = ny + SW'(FIELD_MAX + 1);
      else if (ny > SW'(FIELD_MAX)) ny = ny - SW'(FIELD_MAX + 1);
      w_retire[i] = 1'b0 & (lim < 0);
`else
      w_retire[i] = (nx < 0) || (nx > lim) || (ny < 0) || (ny > lim);
`endif
      w_px[i] = nx[COORD_W-1:0];
      w_py[i] = ny[COORD_W-1:0];
    end
  end

  assign w_iframe_idle = (r_iframe == '0);

  always_comb begin
    for (int i = 0; i < N_BULLETS; i++) begin
      w_eligible[i] = r_slot[i].live && w_overlap[i] && w_iframe_idle &&
                      ((r_slot[i].color != BLUE) || player_moving);
    end
  end

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    w_free_any  = 1'b0;
    w_free_idx  = '0;
    w_hit_any   = 1'b0;
    w_hit_idx   = '0;
    w_hit_color = '0;
    w_count     = '0;
    w_live      = '0;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      w_live[i] = r_slot[i].live;
      w_count   = w_count + CNT_W'(r_slot[i].live);
      if (!r_slot[i].live) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (w_eligible[i]) begin
        w_hit_any   = 1'b1;
        w_hit_idx   = IDX_W'(i);
        w_hit_color = r_slot[i].color;
      end
    end
  end

  assign spawn_ready = run && w_free_any;
  assign w_accept    = spawn_valid && spawn_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_BULLETS; i++) r_slot[i] <= '0;
      r_hit_valid <= 1'b0;
      r_hit_index <= '0;
      r_hit_color <= '0;
      r_iframe    <= '0;
    end else begin
      r_hit_valid <= run && w_hit_any;
      if (run && w_hit_any) begin
        r_hit_index <= w_hit_idx;
        r_hit_color <= w_hit_color;
        r_iframe    <= IFW'(IFRAME_TICKS);
      end else if (tick && !w_iframe_idle) begin
        r_iframe <= r_iframe - IFW'(1);
      end
      // A hit outranks movement; spawns only ever land in slots that are not live.
      for (int i = 0; i < N_BULLETS; i++) begin
        if (!run) begin
          r_slot[i].live <= 1'b0;
        end else if (w_hit_any && (w_hit_idx == IDX_W'(i))) begin
          r_slot[i].live <= 1'b0;
        end else if (r_slot[i].live && tick) begin
          if (w_retire[i]) begin
            r_slot[i].live <= 1'b0;
          end else begin
            r_slot[i].x <= w_px[i];
            r_slot[i].y <= w_py[i];
          end
        end else if (w_accept && (w_free_idx == IDX_W'(i))) begin
          r_slot[i].live  <= 1'b1;
          r_slot[i].x     <= spawn_x;
          r_slot[i].y     <= spawn_y;
          r_slot[i].dx    <= spawn_dx;
          r_slot[i].dy    <= spawn_dy;
          r_slot[i].size  <= spawn_size;
          r_slot[i].color <= spawn_color;
        end
      end
    end
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < N_BULLETS; i++) begin
      if (rd_idx == IDX_W'(i)) w_rd = r_slot[i];
    end
  end

  assign rd_x          = w_rd.x;
  assign rd_y          = w_rd.y;
  assign rd_size       = w_rd.size;
  assign rd_color      = w_rd.color;
  assign rd_live       = w_rd.live;
  assign hit_valid     = r_hit_valid;
  assign hit_index     = r_hit_index;
  assign hit_color     = r_hit_color;
  assign iframe_active = !w_iframe_idle;
  assign live_mask     = w_live;
  assign live_count    = w_count;

endmodule
